div_ratio_detector: RTL

DIV_RATIO_DETECTOR -- requirements
Module: div_ratio_detector

---
 rtl/div_ratio_detector.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/div_ratio_detector.sv
// Measures the period and high time of an asynchronous divided clock in clk
// cycles, reporting lock after LOCK_N identical periods and a stall timeout.
module div_ratio_detector #(
  parameter int CNT_W  = 5,
  parameter int LOCK_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               MATCH_W = $clog2(LOCK_N + 1) + 1;
  localparam logic [MATCH_W-1:0] MATCH_SAT = MATCH_W'(LOCK_N);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_rise;
  logic w_fall;

  logic [CNT_W-1:0]   r_per_cnt;
  logic [CNT_W-1:0]   r_high_cnt;
  logic [CNT_W-1:0]   w_per_cnt_nxt;
  logic [CNT_W-1:0]   w_high_cnt_nxt;
  logic               w_per_sat;

  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_high_time;
  logic               r_valid;
  logic               r_locked;
  logic               r_timeout;

  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic               w_capture;
  logic               w_timeout_evt;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_per_sat = (r_per_cnt == CNT_MAX);

  always_comb begin
    w_per_cnt_nxt  = r_per_cnt;
    w_high_cnt_nxt = r_high_cnt;
    if (w_rise) begin
      w_per_cnt_nxt  = CNT_ONE;
      w_high_cnt_nxt = CNT_ONE;
    end else begin
      if (!w_per_sat) begin
        w_per_cnt_nxt = r_per_cnt + 1'b1;
      end
      // After the fall the high count freezes until the next rise reloads it.
      if (r_s2 && !w_fall && (r_high_cnt != CNT_MAX)) begin
        w_high_cnt_nxt = r_high_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = ARMED;
        end
      end
      ARMED, MEASURE: begin
        // A rise on the saturating cycle still counts as a valid capture.
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_capture   = 1'b1;
        end else if (w_per_sat) begin
          w_state_nxt   = IDLE;
          w_timeout_evt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_match_nxt = MATCH_ONE;
    if ((r_match != '0) && (r_per_cnt == r_period)) begin
      w_match_nxt = (r_match == MATCH_SAT) ? r_match : r_match + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_state    <= IDLE;
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
    end else begin
      r_s1       <= div_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_state    <= w_state_nxt;
      r_per_cnt  <= w_per_cnt_nxt;
      r_high_cnt <= w_high_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
      r_match     <= '0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_period    <= r_per_cnt;
        r_high_time <= r_high_cnt;
        r_match     <= w_match_nxt;
        r_locked    <= (w_match_nxt >= MATCH_SAT);
      end else if (w_timeout_evt) begin
        r_match  <= '0;
        r_locked <= 1'b0;
      end
      if (w_timeout_evt) begin
        r_timeout <= 1'b1;
      end else if (w_rise) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign timeout   = r_timeout;

endmodule
